// File: rtl/fir_requant_out.sv
// Output requantizer: round-half-up shift, saturate to OUT_W,
// FWFT FIFO toward the consumer, sticky saturation/drop counters.
module fir_requant_out #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 8,
  parameter int SHIFT = 7,
  parameter int DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic signed [IN_W-1:0]           din,
  input  logic                             din_valid,
  output logic signed [OUT_W-1:0]          dout,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [$clog2(DEPTH+1)-1:0]       fifo_level,
  output logic [15:0]                      sat_count,
  output logic [15:0]                      drop_count,
  input  logic                             clr_counts
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic signed [IN_W:0] RND =
    $signed((IN_W+1)'(2**(SHIFT-1)));
  localparam logic signed [IN_W:0] MAXV =
    $signed((IN_W+1)'(2**(OUT_W-1)-1));
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  localparam logic [OUT_W-1:0] QMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] QMIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] t_sum;
  logic signed [IN_W:0] t_shr;
  logic [OUT_W-1:0]     q_next;
  logic                 sat_next;

  logic                 s1_valid;
  logic [OUT_W-1:0]     s1_data;
  logic                 s1_sat;

  logic [OUT_W-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;

  logic full;
  logic push;
  logic pop;
  logic drop;

  // Round, shift and clamp the incoming sample (extra bit: no wrap)
  always_comb begin
    t_sum    = $signed({din[IN_W-1], din}) + RND;
    t_shr    = t_sum >>> SHIFT;
    q_next   = t_shr[OUT_W-1:0];
    sat_next = 1'b0;
    unique case (1'b1)
      (t_shr > MAXV): begin
        q_next   = QMAX;
        sat_next = 1'b1;
      end
      (t_shr < MINV): begin
        q_next   = QMIN;
        sat_next = 1'b1;
      end
      default: ;
    endcase
  end

  // Stage-1 requant register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_sat   <= 1'b0;
    end else begin
      s1_valid <= din_valid;
      if (din_valid) begin
        s1_data <= q_next;
        s1_sat  <= sat_next;
      end
    end
  end

  // FIFO handshake decode; a pop frees the slot for a same-cycle push
  always_comb begin
    full = (fifo_level == LW'(DEPTH));
    pop  = dout_valid & dout_ready;
    push = s1_valid & (~full | pop);
    drop = s1_valid & full & ~pop;
  end

  assign dout_valid = (fifo_level != '0);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s1_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: ;
      endcase
    end
  end

  // Sticky event counters; clear wins over increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else if (clr_counts) begin
      sat_count  <= '0;
      drop_count <= '0;
    end else begin
      if (s1_valid && s1_sat && sat_count != 16'hFFFF)
        sat_count <= sat_count + 16'd1;
      if (drop && drop_count != 16'hFFFF)
        drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fir_requant_out.sv
// Directed bench for fir_requant_out: rounding, saturation,
// full/drop, latency, async reset and counter limits.
module tb_fir_requant_out;

  logic               clk = 1'b0;
  logic               reset_n;
  logic signed [15:0] din;
  logic               din_valid;
  logic signed [7:0]  dout;
  logic               dout_valid;
  logic               dout_ready;
  logic [2:0]         fifo_level;
  logic [15:0]        sat_count;
  logic [15:0]        drop_count;
  logic               clr_counts;

  int checks = 0;
  int errors = 0;

  fir_requant_out #(
    .IN_W(16), .OUT_W(8), .SHIFT(7), .DEPTH(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fifo_level (fifo_level),
    .sat_count  (sat_count),
    .drop_count (drop_count),
    .clr_counts (clr_counts)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    clr_counts = 1'b0;
    #2;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL reset_out got v=%b d=%h l=%0d want 0 0 0",
               dout_valid, dout, fifo_level);
    end
    checks++;
    if (sat_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got %h %h want 0 0", sat_count, drop_count);
    end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_rounding();
    int         vin  [5] = '{64, 63, -64, -65, 256};
    logic [7:0] vexp [5] = '{8'h01, 8'h00, 8'h00, 8'hFF, 8'h02};
    dout_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din       = 16'(vin[i]);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== vexp[i]) begin
        errors++;
        $display("FAIL round_%0d got v=%b d=%h want v=1 d=%h",
                 vin[i], dout_valid, dout, vexp[i]);
      end
      tick();
      checks++;
      if (dout_valid !== 1'b0 || dout !== 8'h00) begin
        errors++;
        $display("FAIL round_drain_%0d got v=%b d=%h want 0 0",
                 vin[i], dout_valid, dout);
      end
    end
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL round_sat got %0d want 0", sat_count);
    end
  endtask

  task automatic test_saturation();
    int         vin  [3] = '{16384, 32767, -32768};
    logic [7:0] vexp [3] = '{8'h7F, 8'h7F, 8'h80};
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din       = 16'(vin[i]);
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout !== vexp[i]) begin
        errors++;
        $display("FAIL sat_%0d got v=%b d=%h want v=1 d=%h",
                 vin[i], dout_valid, dout, vexp[i]);
      end
      tick();
    end
    checks++;
    if (sat_count !== 16'd3) begin
      errors++;
      $display("FAIL sat_count got %0d want 3", sat_count);
    end
  endtask

  task automatic test_full();
    dout_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      din       = 16'(k * 256);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    checks++;
    if (fifo_level !== 3'd4 || drop_count !== 16'd2) begin
      errors++;
      $display("FAIL full_drop got l=%0d drop=%0d want 4 2",
               fifo_level, drop_count);
    end
    checks++;
    if (dout !== 8'h02) begin
      errors++;
      $display("FAIL full_head_stable got %h want 02", dout);
    end
    dout_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'(2 * k)) begin
        errors++;
        $display("FAIL full_drain_%0d got v=%b d=%h want v=1 d=%h",
                 k, dout_valid, dout, 8'(2 * k));
      end
      tick();
    end
    checks++;
    if (dout_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL full_empty got v=%b l=%0d want 0 0",
               dout_valid, fifo_level);
    end

    dout_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      din       = 16'(k * 256);
      din_valid = 1'b1;
      tick();
    end
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    checks++;
    if (fifo_level !== 3'd4 || dout !== 8'h02) begin
      errors++;
      $display("FAIL fullpop_pre got l=%0d d=%h want 4 02",
               fifo_level, dout);
    end
    tick();
    dout_ready = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || drop_count !== 16'd2 || dout !== 8'h04) begin
      errors++;
      $display("FAIL fullpop got l=%0d drop=%0d d=%h want 4 2 04",
               fifo_level, drop_count, dout);
    end
    dout_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'(2 * k)) begin
        errors++;
        $display("FAIL fullpop_drain_%0d got v=%b d=%h want v=1 d=%h",
                 k, dout_valid, dout, 8'(2 * k));
      end
      tick();
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_empty got v=%b want 0", dout_valid);
    end
  endtask

  task automatic test_latency();
    dout_ready = 1'b1;
    din        = 16'sd256;
    din_valid  = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat_e0 got v=%b want 0", dout_valid);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h02) begin
      errors++;
      $display("FAIL lat_e1 got v=%b d=%h want 1 02", dout_valid, dout);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL lat_e2 got v=%b d=%h want 0 00", dout_valid, dout);
    end
  endtask

  task automatic test_async_reset();
    dout_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      din       = 16'(k * 256);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    tick();
    checks++;
    if (fifo_level !== 3'd3 || sat_count !== 16'd3 ||
        drop_count !== 16'd2) begin
      errors++;
      $display("FAIL ar_pre got l=%0d s=%0d d=%0d want 3 3 2",
               fifo_level, sat_count, drop_count);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || fifo_level !== 3'd0 ||
        sat_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL ar_async got v=%b d=%h l=%0d s=%0d dr=%0d want 0s",
               dout_valid, dout, fifo_level, sat_count, drop_count);
    end
    tick();
    reset_n    = 1'b1;
    dout_ready = 1'b1;
    din        = 16'sd256;
    din_valid  = 1'b1;
    tick();
    din_valid = 1'b0;
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL ar_post_e0 got v=%b want 0", dout_valid);
    end
    tick();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h02 || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL ar_post_e1 got v=%b d=%h l=%0d want 1 02 1",
               dout_valid, dout, fifo_level);
    end
    tick();
  endtask

  task automatic test_counter_limits();
    dout_ready = 1'b1;
    din        = 16'sd32767;
    din_valid  = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    din_valid = 1'b0;
    tick();
    checks++;
    if (sat_count !== 16'hFFFF || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL sat_sticky got s=%h d=%h want FFFF 0000",
               sat_count, drop_count);
    end
    tick();
    tick();
    din       = 16'sd32767;
    din_valid = 1'b1;
    tick();
    din_valid  = 1'b0;
    clr_counts = 1'b1;
    tick();
    clr_counts = 1'b0;
    checks++;
    if (sat_count !== 16'd0) begin
      errors++;
      $display("FAIL clr_priority got %h want 0000", sat_count);
    end
    din       = -16'sd32768;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    checks++;
    if (sat_count !== 16'd1 || dout !== 8'h80) begin
      errors++;
      $display("FAIL clr_resume got s=%0d d=%h want 1 80", sat_count, dout);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_rounding();
    test_saturation();
    test_full();
    test_latency();
    test_async_reset();
    test_counter_limits();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_requant_out.md
# fir_requant_out

Output-side requantizer for the filter datapath. Accepts the free-running 16-bit signed filter stream (no backpressure), then scales it by an arithmetic right shift with round-half-up. It saturates the result to 8-bit signed and buffers it in a small first-word-fall-through FIFO with a valid/ready handshake toward the downstream consumer. Saturation and overflow-drop events are counted for software visibility.

## Interface
- IN_W, 16, input sample width (signed)
- OUT_W, 8, output sample width (signed)
- SHIFT, 7, right-shift applied before saturation; legal range 1..IN_W-1
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset; one clock, async assert, and this polarity are fixed
- din  in  IN_W  signed filter sample
- din_valid  in  1  din is a new sample this cycle; no ready is returned
- dout  out  OUT_W  signed requantized sample; 0 whenever dout_valid=0
- dout_valid  out  1  FIFO head valid
- dout_ready  in  1  consumer accepts head this cycle
- fifo_level  out  $clog2(DEPTH+1)  entries currently stored
- sat_count  out  16  saturation events, sticky at 0xFFFF
- drop_count  out  16  samples dropped on full FIFO, sticky at 0xFFFF
- clr_counts  in  1  synchronous clear of both counters

## Operation
- Stage 1 (requant register), on each edge with din_valid=1:
  - t = din + 2^(SHIFT-1), computed at IN_W+1 bits so there is no wrap.
  - s = t >>> SHIFT (arithmetic).
  - If s > 2^(OUT_W-1)-1, store 127 and flag sat. If s < -2^(OUT_W-1), store -128 and flag sat.
  - Result and a valid bit go into the stage-1 register. din_valid=0 clears the stage-1 valid bit.
- Stage 2 (FIFO):
  - Push when stage-1 valid, unless the FIFO is full and no pop occurs this cycle.
  - Pop when dout_valid && dout_ready.
- Full FIFO:
  - A full FIFO with a simultaneous pop accepts the push, and the level is unchanged.
  - A full FIFO with no pop drops the stage-1 sample. drop_count increments; FIFO contents are untouched.
- Empty FIFO: no pop possible. A push becomes visible on dout the next cycle.
- Order is preserved; no sample is duplicated.
- The head (dout) stays stable while dout_valid=1 and dout_ready=0.
- sat_count increments when a saturated sample leaves stage 1 into the FIFO, and also when that sample is dropped. Saturation is counted independently of drop.
- Both counters hold at 0xFFFF.
- clr_counts=1 zeroes both counters and takes priority over any increment in the same cycle.
- Reset (reset_n low, any time, no clock needed):
  - Stage-1 valid=0, FIFO pointers and level=0, dout_valid=0, dout=0, sat_count=0, drop_count=0.
  - In-flight and stored samples are discarded.

## Timing
- Latency: din_valid at edge N → stage 1 at N → FIFO at N+1. dout_valid rises after edge N+1 when the FIFO was empty: 2 cycles.
- Throughput: one sample per cycle in and out when dout_ready=1 continuously.
- fifo_level, dout_valid, and the counters update on the same edge as the push, pop, or drop that causes them.
- Reset release: first sample accepted on the first rising edge with reset_n=1 and din_valid=1.
- No combinational path from din or din_valid to any output. dout_valid does not depend on dout_ready.

## Test plan
- Rounding (SHIFT=7, dout_ready=1):
  - din 64 → dout 1.
  - din 63 → 0.
  - din -64 → 0.
  - din -65 → -1 (0xFF).
  - din 256 → 2.
  - sat_count stays 0.
- Saturation:
  - din 16384 → 127 (0x7F).
  - din 32767 → 127; the 17-bit add does not wrap.
  - din -32768 → -128 (0x80).
  - sat_count=3.
- Backpressure/full: dout_ready=0, six consecutive valid samples 256,512,…,1536.
  - fifo_level=4, drop_count=2.
  - Then dout_ready=1 → dout 2,4,6,8 on consecutive cycles, then dout_valid=0.
  - Same sequence with pop on the full cycle → no drop.
- Latency: single din 256 at edge 0 with dout_ready=1 → dout_valid=1, dout=2 only after edge 1, back to 0 after edge 2.
- Async reset mid-operation: FIFO holding 3 entries, counters nonzero.
  - Pull reset_n low between edges → all outputs 0 before the next edge.
  - After release, the first new sample appears with 2-cycle latency.
- Counter limits: force 65537 saturating samples → sat_count=0xFFFF. clr_counts asserted during a saturating sample → sat_count=0 next cycle.
